// File: rtl/pool_relu_2x2_10lane_if.sv
// Row-stream handshake bundle for the 2x2 ReLU/max-pool stage.
// The slave modport is the pooling block; the master modport is its environment.
interface pool_relu_2x2_10lane_if #(
  parameter int LANES = 10,
  parameter int DW    = 20
);
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*DW-1:0]       in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [(LANES/2)*DW-1:0]   out_data;
  logic                      out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/pool_relu_2x2_10lane.sv
// Optional ReLU followed by 2x2 max pooling over pairs of conv rows; one pooled row per pair.
// Macro POOL_RELU_EN: when defined, negative lanes clamp to 0 before pooling.
module pool_relu_2x2_10lane #(
  parameter int LANES = 10,
  parameter int DW    = 20,
  parameter int ROWS  = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  pool_relu_2x2_10lane_if.slave  bus
);

  localparam int PAIRS = ROWS / 2;
  localparam int CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int OLANES = LANES / 2;

  typedef enum logic [0:0] {
    S_EVEN = 1'b0,
    S_ODD  = 1'b1
  } state_t;

  state_t                  r_state;
  logic [LANES*DW-1:0]     r_row_buf;
  logic [OLANES*DW-1:0]    r_out_data;
  logic                    r_out_valid;
  logic                    r_out_last;
  logic [CW-1:0]           r_pair_cnt;

  logic [LANES*DW-1:0]     w_act;
  logic [OLANES*DW-1:0]    w_pool;
  logic                    w_in_ready;
  logic                    w_in_xfer;
  logic                    w_out_xfer;
  logic                    w_load;

  function automatic logic [DW-1:0] act_fn(input logic [DW-1:0] x);
`ifdef POOL_RELU_EN
    act_fn = x[DW-1] ? {DW{1'b0}} : x;
`else
    act_fn = x;
`endif
  endfunction

  function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    smax = ($signed(a) > $signed(b)) ? a : b;
  endfunction

  // Lanewise activation of the incoming row and the four-way pooled result.
  always_comb begin
    w_act  = '0;
    w_pool = '0;
    for (int i = 0; i < LANES; i++) begin
      w_act[i*DW +: DW] = act_fn(bus.in_data[i*DW +: DW]);
    end
    for (int j = 0; j < OLANES; j++) begin
      w_pool[j*DW +: DW] = smax(smax(r_row_buf[(2*j)*DW +: DW], r_row_buf[(2*j+1)*DW +: DW]),
                                smax(w_act[(2*j)*DW +: DW], w_act[(2*j+1)*DW +: DW]));
    end
  end

  // Only the second row of a pair needs room in the output register.
  always_comb begin
    w_in_ready = 1'b1;
    if (r_state == S_ODD) begin
      w_in_ready = ~r_out_valid | bus.out_ready;
    end else begin
      w_in_ready = 1'b1;
    end
    w_in_xfer  = bus.in_valid & w_in_ready;
    w_out_xfer = r_out_valid & bus.out_ready;
    w_load     = w_in_xfer & (r_state == S_ODD);
  end

  // Pair FSM, row buffer, pooled output register and frame pair counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_EVEN;
      r_row_buf   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_pair_cnt  <= '0;
    end else begin
      case (r_state)
        S_EVEN: begin
          if (w_in_xfer) begin
            r_row_buf <= w_act;
            r_state   <= S_ODD;
          end
        end
        S_ODD: begin
          if (w_in_xfer) begin
            r_state <= S_EVEN;
          end
        end
        default: r_state <= S_EVEN;
      endcase

      // A load in the same cycle as a drain keeps out_valid high with fresh data.
      if (w_load) begin
        r_out_data  <= w_pool;
        r_out_valid <= 1'b1;
        r_out_last  <= (r_pair_cnt == CW'(PAIRS - 1));
        r_pair_cnt  <= (r_pair_cnt == CW'(PAIRS - 1)) ? '0 : r_pair_cnt + CW'(1);
      end else if (w_out_xfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;

endmodule
